rv32i_multicycle_ctrl: RTL and testbench
========================================

// Module: rv32i_multicycle_ctrl
// PURPOSE
//  Main sequencing FSM of the multicycle RV32I core. Owns the PC and the instruction register (IR).
//  Drives instruction fetch and holds the IR stable for the combinational decoder.
//  Uses the decoder's class flags to step EXECUTE / MEMORY / WRITEBACK, then retires and updates the PC.
//  Traps, sticky until reset, on an invalid instruction, a misaligned branch target or a memory timeout.
// PARAMETERS
//  WORD_SIZE     32     datapath / PC width
//  RESET_VECTOR  32'h0  PC value loaded on reset
//  MEM_TIMEOUT   255    max cycles waiting in FETCH or MEMORY before a timeout trap (range 1..255)
// PORTS
//  i_clk             in   1          core clock
//  i_reset           in   1          synchronous, active-high reset
//  o_imem_req        out  1          instruction fetch request
//  o_imem_addr       out  WORD_SIZE  fetch address (= o_pc)
//  i_imem_valid      in   1          i_imem_data valid this cycle
//  i_imem_data       in   32         fetched instruction word
//  o_ir              out  32         instruction register, feeds the decoder
//  i_dec_invalid     in   1          decoder: invalid instruction
//  i_dec_b_type      in   1          decoder: conditional branch
//  i_dec_ld          in   1          decoder: load
//  i_dec_str         in   1          decoder: store
//  i_dec_wb_en       in   1          decoder: writeback enabled
//  i_branch_taken    in   1          branch unit: condition true (sampled in EXECUTE)
//  i_branch_target   in   WORD_SIZE  branch unit: target address
//  o_alu_en          out  1          ALU / branch unit operands valid (EXECUTE)
//  o_dmem_req        out  1          data memory request (MEMORY)
//  i_dmem_ack        in   1          data memory access complete
//  o_rf_we           out  1          register file write enable (WRITEBACK)
//  o_pc              out  WORD_SIZE  architectural PC
//  o_retire_count    out  32         retired-instruction counter
//  o_trap            out  1          sticky trap flag
//  o_trap_cause      out  2          0 none, 1 illegal, 2 misaligned, 3 timeout
//  o_state           out  3          current FSM state (debug)
// BEHAVIOUR
//  Reset (i_reset=1 at posedge), cycle after:
//   - state=FETCH, o_pc=RESET_VECTOR, o_ir=32'h0000_0013 (NOP)
//   - o_retire_count=0, o_trap=0, o_trap_cause=0, wait counter=0
//   - o_imem_req=1 (reset has priority from any state, including mid-access)
//  States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5.
//  Outputs are Moore, decoded from state:
//   - o_imem_req=FETCH, o_alu_en=EXECUTE, o_dmem_req=MEMORY, o_rf_we=WRITEBACK
//  FETCH:
//   - o_imem_req held high until i_imem_valid
//   - on valid: IR<=i_imem_data, go DECODE
//  DECODE (1 cycle): i_dec_invalid -> TRAP cause 1, else EXECUTE.
//  EXECUTE (1 cycle):
//   - ld|str -> MEMORY
//   - b_type & taken: target[1:0]!=0 -> TRAP cause 2 (PC unchanged); else retire, PC<=target, FETCH
//   - b_type & not taken: retire, PC<=PC+4, FETCH
//   - wb_en -> WRITEBACK; otherwise retire, PC<=PC+4, FETCH
//  MEMORY: hold o_dmem_req until i_dmem_ack; then ld -> WRITEBACK, str -> retire, PC+4, FETCH.
//  WRITEBACK (1 cycle): retire, PC<=PC+4, FETCH.
//  Retire:
//   - o_retire_count+=1, wrapping at 2^32
//   - exactly one increment per instruction, in the same cycle as the PC update
//  Wait counter (8 bit):
//   - cleared on entry to FETCH/MEMORY; increments each cycle without valid/ack
//   - reaching MEM_TIMEOUT -> TRAP cause 3
//   - valid/ack in the same cycle as the limit wins (no trap)
//  TRAP:
//   - all request/enable outputs 0; PC, IR and count frozen
//   - leaves only on reset
//  PC arithmetic: modulo 2^WORD_SIZE (0xFFFF_FFFC+4 -> 0).
//  Latency: ALU op = fetch wait + 4 cycles; store = fetch wait + ack wait + 4; load = fetch wait + ack wait + 5.
// STRUCTURE
//  Shared core package: ctrl_state_t enum, trap_cause_t enum, NOP_INSTR constant.
//  Single module; no sub-module (FSM + PC/IR/counter registers only).
// TESTING
//  1 addi at 0x0, imem valid 1 cycle after req -> rf_we in cycle 4, PC=0x4, retire=1.
//  2 lw with dmem ack after 3 cycles -> MEMORY held 3 cycles, then WRITEBACK, PC=0x4, retire=1.
//  3 beq taken, target 0x100 -> PC=0x100, no rf_we; target 0x102 -> TRAP cause 2, PC unchanged.
//  4 invalid flag in DECODE -> TRAP cause 1, imem_req stays 0 for 20 cycles, reset -> FETCH at RESET_VECTOR.
//  5 MEM_TIMEOUT=4, imem never valid -> TRAP cause 3 after 4 FETCH cycles; valid on cycle 4 -> no trap.
//  6 i_reset asserted mid-MEMORY with dmem_req high -> next cycle FETCH, dmem_req=0, retire=0.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I sequencing controller.
package rv32i_multicycle_ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CAUSE_W = 2;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } ctrl_state_t;

    typedef enum logic [CAUSE_W-1:0] {
        TRAP_NONE       = 2'd0,
        TRAP_ILLEGAL    = 2'd1,
        TRAP_MISALIGNED = 2'd2,
        TRAP_TIMEOUT    = 2'd3
    } trap_cause_t;

    // Per-state request/enable strobes, registered alongside the state.
    typedef struct packed {
        logic imem_req;
        logic alu_en;
        logic dmem_req;
        logic rf_we;
    } ctrl_out_t;

    // Moore decode of the strobes for the state being entered.
    function automatic ctrl_out_t moore_out(input ctrl_state_t s);
        ctrl_out_t o;
        o          = '0;
        o.imem_req = (s == S_FETCH);
        o.alu_en   = (s == S_EXECUTE);
        o.dmem_req = (s == S_MEMORY);
        o.rf_we    = (s == S_WRITEBACK);
        return o;
    endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl.sv
// Main sequencing FSM of the multicycle RV32I core: owns PC, IR and retire counter.
module rv32i_multicycle_ctrl
    import rv32i_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned          WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
    parameter int unsigned          MEM_TIMEOUT  = 255
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    output logic                 o_imem_req,
    output logic [WORD_SIZE-1:0] o_imem_addr,
    input  logic                 i_imem_valid,
    input  logic [INSTR_W-1:0]   i_imem_data,
    output logic [INSTR_W-1:0]   o_ir,
    input  logic                 i_dec_invalid,
    input  logic                 i_dec_b_type,
    input  logic                 i_dec_ld,
    input  logic                 i_dec_str,
    input  logic                 i_dec_wb_en,
    input  logic                 i_branch_taken,
    input  logic [WORD_SIZE-1:0] i_branch_target,
    output logic                 o_alu_en,
    output logic                 o_dmem_req,
    input  logic                 i_dmem_ack,
    output logic                 o_rf_we,
    output logic [WORD_SIZE-1:0] o_pc,
    output logic [31:0]          o_retire_count,
    output logic                 o_trap,
    output logic [CAUSE_W-1:0]   o_trap_cause,
    output logic [STATE_W-1:0]   o_state
);

    // Wait counter value at which a further idle cycle would reach the timeout.
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);

    ctrl_state_t          state;
    ctrl_out_t            outs;
    trap_cause_t          cause;
    logic [WORD_SIZE-1:0] pc;
    logic [INSTR_W-1:0]   ir;
    logic [31:0]          retire_count;
    logic                 trap;
    logic [WAIT_W-1:0]    wait_cnt;

    // Sequencing FSM with PC/IR/retire/wait registers; strobes registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_FETCH;
            outs         <= moore_out(S_FETCH);
            pc           <= RESET_VECTOR;
            ir           <= NOP_INSTR;
            retire_count <= '0;
            trap         <= 1'b0;
            cause        <= TRAP_NONE;
            wait_cnt     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (i_imem_valid) begin
                        ir    <= i_imem_data;
                        state <= S_DECODE;
                        outs  <= moore_out(S_DECODE);
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state <= S_TRAP;
                        outs  <= moore_out(S_TRAP);
                        trap  <= 1'b1;
                        cause <= TRAP_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_DECODE: begin
                    if (i_dec_invalid) begin
                        state <= S_TRAP;
                        outs  <= moore_out(S_TRAP);
                        trap  <= 1'b1;
                        cause <= TRAP_ILLEGAL;
                    end else begin
                        state <= S_EXECUTE;
                        outs  <= moore_out(S_EXECUTE);
                    end
                end

                S_EXECUTE: begin
                    if (i_dec_ld || i_dec_str) begin
                        wait_cnt <= '0;
                        state    <= S_MEMORY;
                        outs     <= moore_out(S_MEMORY);
                    end else if (i_dec_b_type && i_branch_taken) begin
                        if (i_branch_target[1:0] != 2'b00) begin
                            state <= S_TRAP;
                            outs  <= moore_out(S_TRAP);
                            trap  <= 1'b1;
                            cause <= TRAP_MISALIGNED;
                        end else begin
                            pc           <= i_branch_target;
                            retire_count <= retire_count + 32'd1;
                            wait_cnt     <= '0;
                            state        <= S_FETCH;
                            outs         <= moore_out(S_FETCH);
                        end
                    end else if (!i_dec_b_type && i_dec_wb_en) begin
                        state <= S_WRITEBACK;
                        outs  <= moore_out(S_WRITEBACK);
                    end else begin
                        pc           <= pc + PC_STEP;
                        retire_count <= retire_count + 32'd1;
                        wait_cnt     <= '0;
                        state        <= S_FETCH;
                        outs         <= moore_out(S_FETCH);
                    end
                end

                S_MEMORY: begin
                    if (i_dmem_ack) begin
                        if (i_dec_ld) begin
                            state <= S_WRITEBACK;
                            outs  <= moore_out(S_WRITEBACK);
                        end else begin
                            pc           <= pc + PC_STEP;
                            retire_count <= retire_count + 32'd1;
                            wait_cnt     <= '0;
                            state        <= S_FETCH;
                            outs         <= moore_out(S_FETCH);
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state <= S_TRAP;
                        outs  <= moore_out(S_TRAP);
                        trap  <= 1'b1;
                        cause <= TRAP_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_WRITEBACK: begin
                    pc           <= pc + PC_STEP;
                    retire_count <= retire_count + 32'd1;
                    wait_cnt     <= '0;
                    state        <= S_FETCH;
                    outs         <= moore_out(S_FETCH);
                end

                S_TRAP: begin
                    state <= S_TRAP;
                    outs  <= moore_out(S_TRAP);
                end

                default: begin
                    // Unreachable encodings park in TRAP with the strobes off.
                    state <= S_TRAP;
                    outs  <= moore_out(S_TRAP);
                    trap  <= 1'b1;
                end
            endcase
        end
    end

    assign o_imem_req     = outs.imem_req;
    assign o_alu_en       = outs.alu_en;
    assign o_dmem_req     = outs.dmem_req;
    assign o_rf_we        = outs.rf_we;
    assign o_imem_addr    = pc;
    assign o_pc           = pc;
    assign o_ir           = ir;
    assign o_retire_count = retire_count;
    assign o_trap         = trap;
    assign o_trap_cause   = cause;
    assign o_state        = state;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: environment acts as memories/decoder, predicts per-instruction outcome.
module tb_rv32i_multicycle_ctrl;

    localparam int TMO   = 4;
    localparam int K_ALU = 0;
    localparam int K_AWB = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;
    localparam int K_BR  = 4;
    localparam int K_INV = 5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic        dec_invalid, dec_b_type, dec_ld, dec_str, dec_wb_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        alu_en, dmem_req, dmem_ack, rf_we;
    logic [31:0] pc;
    logic [31:0] retire_count;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    int tests;
    int fails;

    logic [31:0] m_pc;
    logic [31:0] m_retire;
    logic [31:0] m_ir;

    rv32i_multicycle_ctrl #(
        .WORD_SIZE   (32),
        .RESET_VECTOR(32'h0),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_valid   (imem_valid),
        .i_imem_data    (imem_data),
        .o_ir           (ir),
        .i_dec_invalid  (dec_invalid),
        .i_dec_b_type   (dec_b_type),
        .i_dec_ld       (dec_ld),
        .i_dec_str      (dec_str),
        .i_dec_wb_en    (dec_wb_en),
        .i_branch_taken (branch_taken),
        .i_branch_target(branch_target),
        .o_alu_en       (alu_en),
        .o_dmem_req     (dmem_req),
        .i_dmem_ack     (dmem_ack),
        .o_rf_we        (rf_we),
        .o_pc           (pc),
        .o_retire_count (retire_count),
        .o_trap         (trap),
        .o_trap_cause   (trap_cause),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply reset for one edge and check the architectural reset state.
    task automatic do_reset();
        rst        = 1'b1;
        imem_valid = 1'b0;
        dmem_ack   = 1'b0;
        step();
        rst = 1'b0;
        m_pc     = 32'h0;
        m_retire = 32'h0;
        m_ir     = NOP;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", pc, m_pc);
        check("rst_ir", ir, m_ir);
        check("rst_retire", retire_count, m_retire);
        check("rst_trap", {30'd0, trap_cause} | 32'({trap, 2'b00}), 32'd0);
        check("rst_strobes", 32'({imem_req, alu_en, dmem_req, rf_we}), 32'b1000);
    endtask

    // Drive one instruction through the DUT and compare against the predicted outcome.
    task automatic run_instr(input int kind, input int fw, input int aw,
                             input logic taken, input logic [31:0] tgt);
        int cyc, fcyc, mcyc, we, we_at, alu;
        int e_cyc, e_we, e_we_at, e_mem, e_alu, e_cause;
        logic fetched, done, retire_now;
        logic [31:0] data, e_pc, e_ret, e_ir;
        cyc = 0; fcyc = 0; mcyc = 0; we = 0; we_at = -1; alu = 0;
        fetched = 1'b0; done = 1'b0;
        data = $urandom;

        dec_invalid   = (kind == K_INV);
        dec_b_type    = (kind == K_BR);
        dec_ld        = (kind == K_LD);
        dec_str       = (kind == K_ST);
        dec_wb_en     = (kind == K_AWB) || (kind == K_LD);
        branch_taken  = taken;
        branch_target = tgt;

        check("fetch_addr", imem_addr, m_pc);

        for (int k = 0; k < 60; k++) begin
            imem_valid = 1'b0;
            dmem_ack   = 1'b0;
            if (imem_req) begin
                fcyc++;
                if (fcyc == fw + 1) begin
                    imem_valid = 1'b1;
                    imem_data  = data;
                    fetched    = 1'b1;
                end
            end
            if (dmem_req) begin
                mcyc++;
                if (mcyc == aw + 1) dmem_ack = 1'b1;
            end
            if (rf_we) begin
                we++;
                we_at = cyc;
            end
            if (alu_en) alu++;
            cyc++;
            step();
            if (trap || (fetched && imem_req)) begin
                done = 1'b1;
                break;
            end
        end
        imem_valid = 1'b0;
        dmem_ack   = 1'b0;

        // Predicted outcome from the instruction class and the wait lengths.
        e_cause = 0; e_we = 0; e_we_at = -1; e_mem = 0; e_alu = 0;
        e_pc = m_pc; e_ret = m_retire; e_ir = m_ir;
        if (fw >= TMO) begin
            e_cause = 3;
            e_cyc   = TMO;
        end else begin
            e_ir  = data;
            e_cyc = fw + 2;
            if (kind == K_INV) begin
                e_cause = 1;
            end else begin
                e_alu      = 1;
                e_cyc      = e_cyc + 1;
                retire_now = 1'b1;
                if (kind == K_LD || kind == K_ST) begin
                    if (aw >= TMO) begin
                        e_cause    = 3;
                        e_mem      = TMO;
                        e_cyc      = e_cyc + TMO;
                        retire_now = 1'b0;
                    end else begin
                        e_mem = aw + 1;
                        e_cyc = e_cyc + aw + 1;
                        if (kind == K_LD) begin
                            e_we    = 1;
                            e_we_at = e_cyc;
                            e_cyc   = e_cyc + 1;
                        end
                    end
                end else if (kind == K_BR && taken && tgt[1:0] != 2'b00) begin
                    e_cause    = 2;
                    retire_now = 1'b0;
                end else if (kind == K_AWB) begin
                    e_we    = 1;
                    e_we_at = e_cyc;
                    e_cyc   = e_cyc + 1;
                end
                if (retire_now) begin
                    e_ret = m_retire + 32'd1;
                    e_pc  = (kind == K_BR && taken) ? tgt : m_pc + 32'd4;
                end
            end
        end

        check("finished", 32'(done), 32'd1);
        check("cycles", 32'(cyc), 32'(e_cyc));
        check("rf_we_pulses", 32'(we), 32'(e_we));
        if (e_we != 0) check("rf_we_cycle", 32'(we_at), 32'(e_we_at));
        check("mem_cycles", 32'(mcyc), 32'(e_mem));
        check("alu_pulses", 32'(alu), 32'(e_alu));
        check("trap", 32'(trap), 32'(e_cause != 0));
        check("trap_cause", 32'(trap_cause), 32'(e_cause));
        check("state", 32'(state), (e_cause != 0) ? 32'd5 : 32'd0);
        check("pc", pc, e_pc);
        check("retire", retire_count, e_ret);
        check("ir", ir, e_ir);
        m_pc = e_pc; m_retire = e_ret; m_ir = e_ir;
    endtask

    // Hold the trapped DUT for a while with live inputs; nothing may move.
    task automatic check_frozen(input int n);
        int strobes;
        strobes = 0;
        for (int k = 0; k < n; k++) begin
            imem_valid = 1'b1;
            dmem_ack   = 1'b1;
            step();
            if (imem_req || alu_en || dmem_req || rf_we) strobes++;
        end
        imem_valid = 1'b0;
        dmem_ack   = 1'b0;
        check("frozen_strobes", 32'(strobes), 32'd0);
        check("frozen_pc", pc, m_pc);
        check("frozen_retire", retire_count, m_retire);
        check("frozen_ir", ir, m_ir);
        check("frozen_state", 32'(state), 32'd5);
    endtask

    initial begin
        int seen;
        logic [31:0] tgt;
        tests = 0; fails = 0;
        clk = 1'b0; rst = 1'b1;
        imem_valid = 1'b0; imem_data = '0;
        dec_invalid = 1'b0; dec_b_type = 1'b0; dec_ld = 1'b0; dec_str = 1'b0; dec_wb_en = 1'b0;
        branch_taken = 1'b0; branch_target = '0; dmem_ack = 1'b0;
        m_pc = '0; m_retire = '0; m_ir = NOP;
        step();
        do_reset();

        // addi with one-cycle fetch wait
        run_instr(K_AWB, 1, 0, 1'b0, 32'h0);

        // lw with MEMORY held three cycles
        do_reset();
        run_instr(K_LD, 0, 2, 1'b0, 32'h0);

        // taken branches: aligned then misaligned target
        run_instr(K_BR, 0, 0, 1'b1, 32'h100);
        run_instr(K_BR, 0, 0, 1'b1, 32'h102);
        check_frozen(20);

        // invalid instruction traps and stays stuck until reset
        do_reset();
        run_instr(K_ALU, 0, 0, 1'b0, 32'h0);
        run_instr(K_INV, 2, 0, 1'b0, 32'h0);
        check_frozen(20);
        do_reset();

        // fetch timeout, and valid on the final allowed cycle
        run_instr(K_ALU, 10, 0, 1'b0, 32'h0);
        do_reset();
        run_instr(K_ALU, TMO - 1, 0, 1'b0, 32'h0);
        run_instr(K_ST, 0, TMO - 1, 1'b0, 32'h0);
        run_instr(K_LD, 1, TMO, 1'b0, 32'h0);
        do_reset();

        // PC wraps modulo 2^32; not-taken branch falls through
        run_instr(K_BR, 0, 0, 1'b1, 32'hFFFF_FFFC);
        run_instr(K_ALU, 0, 0, 1'b0, 32'h0);
        run_instr(K_BR, 0, 0, 1'b0, 32'h0000_0203);

        // randomized legal instruction stream
        for (int n = 0; n < 40; n++) begin
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            run_instr(int'($urandom_range(4, 0)), int'($urandom_range(3, 0)),
                      int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), tgt);
        end

        // reset in the middle of a data memory access
        do_reset();
        dec_invalid = 1'b0; dec_b_type = 1'b0; dec_ld = 1'b1; dec_str = 1'b0; dec_wb_en = 1'b1;
        imem_valid = 1'b1;
        imem_data  = 32'h0000_2083;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            imem_valid = 1'b0;
            if (dmem_req) begin
                seen = 1;
                break;
            end
        end
        check("mid_mem_reached", 32'(seen), 32'd1);
        do_reset();
        check("mid_mem_dmem_req", 32'(dmem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
